control: RTL and testbench
==========================

CONTROL -- requirements
Module: control

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 opcode  input  lc3b_opcode (4)  IR opcode field.
REQ-004 branch_enable  input  1  CCCOMP result (nzp match).
REQ-005 imm, bit11, bit4  input  1 each  IR bits 5, 11, 4.
REQ-006 addr_lsb  input  1  MAR bit 0 (byte select).
REQ-007 mem_resp  input  1  memory completion strobe; one cycle per transaction.
REQ-008 load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc  output  1 each  datapath register loads.
REQ-009 mask_enable, truncate, shift  output  1 each  byte mask, SR1 LSB clear, store-byte replicate.
REQ-010 pcmux_sel, alumux_sel, regfilemux_sel, marmux_sel  output  2 each  datapath mux selects.
REQ-011 storemux_sel, mdrmux_sel, adjmux_sel  output  1 each  datapath mux selects.
REQ-012 aluop, aluop_imm  output  lc3b_aluop  main and immediate ALU operations.
REQ-013 mem_read, mem_write  output  1 each  memory request, held until mem_resp.
REQ-014 mem_byte_enable  output  2  write lane enables.

Function
REQ-015 Moore FSM; every output SHALL be decoded combinationally from the current state and IR bits only; any output not listed for a state SHALL be 0 (aluop/aluop_imm = alu_pass, mem_byte_enable = 2'b11).
REQ-016 FETCH1: marmux_sel=1, load_mar, pcmux_sel=0, load_pc; -> FETCH2.
REQ-017 FETCH2: mem_read, mdrmux_sel=1, load_mdr; stays until mem_resp=1, then -> FETCH3.
REQ-018 FETCH3: load_ir; -> DECODE.
REQ-019 DECODE (no outputs) dispatches on opcode: ADD/AND/NOT -> ALU; SHF -> SHF; BR -> BR; JMP -> JMP; JSR -> JSR; LEA -> LEA; LDR/LDB/STR/STB -> CALC_ADDR; RTI, TRAP, LDI, STI, reserved -> FETCH1 (no-op, 1 cycle).
REQ-020 ALU: storemux_sel=0, alumux_sel=0, regfilemux_sel=0, load_regfile, load_cc; imm=1: aluop=alu_pass, aluop_imm=ADD/AND; imm=0: aluop=ADD/AND/NOT, aluop_imm=alu_pass; -> FETCH1.
REQ-021 SHF: alumux_sel=2, aluop = bit4=0 -> alu_sll, bit4=1 & imm=0 -> alu_srl, bit4=1 & imm=1 -> alu_sra; load_regfile, load_cc; -> FETCH1.
REQ-022 BR: branch_enable=1 -> BR_TAKEN else -> FETCH1; BR_TAKEN: pcmux_sel=1, load_pc; -> FETCH1.
REQ-023 JMP: pcmux_sel=2, load_pc; -> FETCH1.
REQ-024 JSR: regfilemux_sel=3, load_regfile; pcmux_sel = bit11 ? 3 : 2, load_pc; single cycle; -> FETCH1.
REQ-025 LEA: regfilemux_sel=2, load_regfile, load_cc; -> FETCH1.
REQ-026 CALC_ADDR: alumux_sel=1, aluop=alu_add, marmux_sel=0, load_mar; adjmux_sel=0 and truncate=1 for LDR/STR, adjmux_sel=1 and truncate=0 for LDB/STB; loads -> LD_MEM, stores -> ST_MDR.
REQ-027 LD_MEM: mem_read, mdrmux_sel=1, load_mdr until mem_resp -> LD_WB; LD_WB: regfilemux_sel=1, load_regfile, load_cc, mask_enable=1 for LDB; -> FETCH1.
REQ-028 ST_MDR: storemux_sel=1, aluop=alu_pass, mdrmux_sel=0, load_mdr, shift=1 for STB; -> ST_MEM.
REQ-029 ST_MEM: mem_write until mem_resp -> FETCH1; mem_byte_enable = 2'b11 for STR, STB: addr_lsb ? 2'b10 : 2'b01.
REQ-030 mem_read and mem_write SHALL never be asserted in the same cycle; mem_resp outside FETCH2/LD_MEM/ST_MEM SHALL be ignored.

Reset
REQ-031 reset=1 at an edge SHALL force state FETCH1 regardless of state, including mid-memory wait; the request drops in the following cycle.
REQ-032 In FETCH1 after reset, only load_mar and load_pc are 1 (marmux_sel=1, pcmux_sel=0); all other outputs are 0 or per REQ-015 defaults.

Structure
REQ-033 State enum and the mux-select encodings SHALL be defined in lc3b_types next to lc3b_opcode and lc3b_aluop.
REQ-034 Single flat module: state register plus combinational output decode and next-state blocks; no sub-modules.

Verification
REQ-035 ADD R1,R2,R3 (imm=0), mem_resp 1 cycle after request -> FETCH1..ALU is 5 cycles; ALU state: aluop=alu_add, load_regfile=1, load_cc=1.
REQ-036 LDR, mem_resp withheld 3 cycles in LD_MEM -> mem_read high 4 cycles, load_mdr high in all 4, LD_WB follows with regfilemux_sel=1.
REQ-037 BR, branch_enable=0 -> DECODE, BR, FETCH1, with load_pc never asserted in BR; branch_enable=1 -> BR_TAKEN with pcmux_sel=1.
REQ-038 STB, addr_lsb=1 -> ST_MDR shift=1, ST_MEM mem_byte_enable=2'b10; addr_lsb=0 -> 2'b01.
REQ-039 reset pulsed during ST_MEM wait -> mem_write low the next cycle, state FETCH1, load_mar=1.
REQ-040 opcode TRAP -> DECODE then FETCH1; no load or mem signal asserted in between.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcodes, ALU operations, control FSM states and
// datapath mux select encodings.
package lc3b_types;

   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned ALUOP_W  = 3;
   localparam int unsigned STATE_W  = 4;
   localparam int unsigned SEL_W    = 2;
   localparam int unsigned MBE_W    = 2;

   typedef enum logic [OPCODE_W-1:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef enum logic [ALUOP_W-1:0] {
      alu_add  = 3'd0,
      alu_and  = 3'd1,
      alu_not  = 3'd2,
      alu_pass = 3'd3,
      alu_sll  = 3'd4,
      alu_srl  = 3'd5,
      alu_sra  = 3'd6
   } lc3b_aluop;

   typedef enum logic [STATE_W-1:0] {
      s_fetch1    = 4'd0,
      s_fetch2    = 4'd1,
      s_fetch3    = 4'd2,
      s_decode    = 4'd3,
      s_alu       = 4'd4,
      s_shf       = 4'd5,
      s_br        = 4'd6,
      s_br_taken  = 4'd7,
      s_jmp       = 4'd8,
      s_jsr       = 4'd9,
      s_lea       = 4'd10,
      s_calc_addr = 4'd11,
      s_ld_mem    = 4'd12,
      s_ld_wb     = 4'd13,
      s_st_mdr    = 4'd14,
      s_st_mem    = 4'd15
   } lc3b_state;

   // Datapath mux select encodings
   localparam logic [SEL_W-1:0] PCMUX_PLUS2     = 2'd0;
   localparam logic [SEL_W-1:0] PCMUX_BR        = 2'd1;
   localparam logic [SEL_W-1:0] PCMUX_SR1       = 2'd2;
   localparam logic [SEL_W-1:0] PCMUX_OFF11     = 2'd3;

   localparam logic [SEL_W-1:0] ALUMUX_SR2      = 2'd0;
   localparam logic [SEL_W-1:0] ALUMUX_ADJ6     = 2'd1;
   localparam logic [SEL_W-1:0] ALUMUX_IMM4     = 2'd2;

   localparam logic [SEL_W-1:0] REGFILEMUX_ALU  = 2'd0;
   localparam logic [SEL_W-1:0] REGFILEMUX_MDR  = 2'd1;
   localparam logic [SEL_W-1:0] REGFILEMUX_LEA  = 2'd2;
   localparam logic [SEL_W-1:0] REGFILEMUX_PC   = 2'd3;

   localparam logic [SEL_W-1:0] MARMUX_ALU      = 2'd0;
   localparam logic [SEL_W-1:0] MARMUX_PC       = 2'd1;

   localparam logic STOREMUX_SR1  = 1'b0;
   localparam logic STOREMUX_DEST = 1'b1;
   localparam logic MDRMUX_ALU    = 1'b0;
   localparam logic MDRMUX_MEM    = 1'b1;
   localparam logic ADJMUX_WORD   = 1'b0;
   localparam logic ADJMUX_BYTE   = 1'b1;

endpackage

// File: rtl/control.sv
// LC-3b multicycle control unit: Moore FSM whose outputs are decoded from the
// current state and IR fields.
module control
   import lc3b_types::*;
(
   input  logic             clk,
   input  logic             reset,
   input  lc3b_opcode       opcode,
   input  logic             branch_enable,
   input  logic             imm,
   input  logic             bit11,
   input  logic             bit4,
   input  logic             addr_lsb,
   input  logic             mem_resp,
   output logic             load_pc,
   output logic             load_ir,
   output logic             load_regfile,
   output logic             load_mar,
   output logic             load_mdr,
   output logic             load_cc,
   output logic             mask_enable,
   output logic             truncate,
   output logic             shift,
   output logic [SEL_W-1:0] pcmux_sel,
   output logic [SEL_W-1:0] alumux_sel,
   output logic [SEL_W-1:0] regfilemux_sel,
   output logic [SEL_W-1:0] marmux_sel,
   output logic             storemux_sel,
   output logic             mdrmux_sel,
   output logic             adjmux_sel,
   output lc3b_aluop        aluop,
   output lc3b_aluop        aluop_imm,
   output logic             mem_read,
   output logic             mem_write,
   output logic [MBE_W-1:0] mem_byte_enable
);

   lc3b_state r_state;
   lc3b_state w_next_state;
   logic      w_byte_op;

   assign w_byte_op = (opcode == op_ldb) || (opcode == op_stb);

   always_ff @(posedge clk) begin
      if (reset) r_state <= s_fetch1;
      else       r_state <= w_next_state;
   end

   // Output decode
   always_comb begin
      load_pc         = 1'b0;
      load_ir         = 1'b0;
      load_regfile    = 1'b0;
      load_mar        = 1'b0;
      load_mdr        = 1'b0;
      load_cc         = 1'b0;
      mask_enable     = 1'b0;
      truncate        = 1'b0;
      shift           = 1'b0;
      pcmux_sel       = PCMUX_PLUS2;
      alumux_sel      = ALUMUX_SR2;
      regfilemux_sel  = REGFILEMUX_ALU;
      marmux_sel      = MARMUX_ALU;
      storemux_sel    = STOREMUX_SR1;
      mdrmux_sel      = MDRMUX_ALU;
      adjmux_sel      = ADJMUX_WORD;
      aluop           = alu_pass;
      aluop_imm       = alu_pass;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = 2'b11;
      case (r_state)
         s_fetch1: begin
            marmux_sel = MARMUX_PC;
            load_mar   = 1'b1;
            pcmux_sel  = PCMUX_PLUS2;
            load_pc    = 1'b1;
         end
         s_fetch2: begin
            mem_read   = 1'b1;
            mdrmux_sel = MDRMUX_MEM;
            load_mdr   = 1'b1;
         end
         s_fetch3: load_ir = 1'b1;
         s_alu: begin
            storemux_sel   = STOREMUX_SR1;
            alumux_sel     = ALUMUX_SR2;
            regfilemux_sel = REGFILEMUX_ALU;
            load_regfile   = 1'b1;
            load_cc        = 1'b1;
            if (opcode == op_not)     aluop     = alu_not;
            else if (opcode == op_and) begin
               if (imm) aluop_imm = alu_and;
               else     aluop     = alu_and;
            end else begin
               if (imm) aluop_imm = alu_add;
               else     aluop     = alu_add;
            end
         end
         s_shf: begin
            alumux_sel   = ALUMUX_IMM4;
            aluop        = !bit4 ? alu_sll : (imm ? alu_sra : alu_srl);
            load_regfile = 1'b1;
            load_cc      = 1'b1;
         end
         s_br_taken: begin
            pcmux_sel = PCMUX_BR;
            load_pc   = 1'b1;
         end
         s_jmp: begin
            pcmux_sel = PCMUX_SR1;
            load_pc   = 1'b1;
         end
         s_jsr: begin
            regfilemux_sel = REGFILEMUX_PC;
            load_regfile   = 1'b1;
            pcmux_sel      = bit11 ? PCMUX_OFF11 : PCMUX_SR1;
            load_pc        = 1'b1;
         end
         s_lea: begin
            regfilemux_sel = REGFILEMUX_LEA;
            load_regfile   = 1'b1;
            load_cc        = 1'b1;
         end
         s_calc_addr: begin
            alumux_sel = ALUMUX_ADJ6;
            aluop      = alu_add;
            marmux_sel = MARMUX_ALU;
            load_mar   = 1'b1;
            adjmux_sel = w_byte_op ? ADJMUX_BYTE : ADJMUX_WORD;
            truncate   = !w_byte_op;
         end
         s_ld_mem: begin
            mem_read   = 1'b1;
            mdrmux_sel = MDRMUX_MEM;
            load_mdr   = 1'b1;
         end
         s_ld_wb: begin
            regfilemux_sel = REGFILEMUX_MDR;
            load_regfile   = 1'b1;
            load_cc        = 1'b1;
            mask_enable    = (opcode == op_ldb);
         end
         s_st_mdr: begin
            storemux_sel = STOREMUX_DEST;
            aluop        = alu_pass;
            mdrmux_sel   = MDRMUX_ALU;
            load_mdr     = 1'b1;
            shift        = (opcode == op_stb);
         end
         s_st_mem: begin
            mem_write = 1'b1;
            if (opcode == op_stb) mem_byte_enable = addr_lsb ? 2'b10 : 2'b01;
         end
         default: ;
      endcase
   end

   // Next-state logic; mem_resp only matters in the three wait states
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         s_fetch1: w_next_state = s_fetch2;
         s_fetch2: if (mem_resp) w_next_state = s_fetch3;
         s_fetch3: w_next_state = s_decode;
         s_decode: begin
            case (opcode)
               op_add, op_and, op_not:        w_next_state = s_alu;
               op_shf:                        w_next_state = s_shf;
               op_br:                         w_next_state = s_br;
               op_jmp:                        w_next_state = s_jmp;
               op_jsr:                        w_next_state = s_jsr;
               op_lea:                        w_next_state = s_lea;
               op_ldr, op_ldb, op_str, op_stb: w_next_state = s_calc_addr;
               default:                       w_next_state = s_fetch1;
            endcase
         end
         s_br:        w_next_state = branch_enable ? s_br_taken : s_fetch1;
         s_calc_addr: w_next_state = ((opcode == op_ldr) || (opcode == op_ldb)) ? s_ld_mem : s_st_mdr;
         s_ld_mem:    if (mem_resp) w_next_state = s_ld_wb;
         s_st_mdr:    w_next_state = s_st_mem;
         s_st_mem:    if (mem_resp) w_next_state = s_fetch1;
         default:     w_next_state = s_fetch1;
      endcase
   end

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: per-cycle expected outputs are derived from
// the instruction-level behaviour and compared against the DUT.
module tb_control;
   import lc3b_types::*;

   typedef struct packed {
      logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
      logic       mask_enable, truncate, shift;
      logic [1:0] pcmux, alumux, regfilemux, marmux;
      logic       storemux, mdrmux, adjmux;
      logic [2:0] aluop, aluop_imm;
      logic       mem_read, mem_write;
      logic [1:0] mbe;
   } out_t;

   typedef struct packed {
      logic [3:0] op;
      logic imm, b11, b4, lsb, be, resp;
   } in_t;

   logic clk, reset, branch_enable, imm, bit11, bit4, addr_lsb, mem_resp;
   lc3b_opcode opcode;
   logic load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
   logic mask_enable, truncate, shift;
   logic [1:0] pcmux_sel, alumux_sel, regfilemux_sel, marmux_sel;
   logic storemux_sel, mdrmux_sel, adjmux_sel;
   lc3b_aluop aluop, aluop_imm;
   logic mem_read, mem_write;
   logic [1:0] mem_byte_enable;

   int n_cmp = 0;
   int n_bad = 0;
   out_t exp_q[$];
   in_t  in_q[$];

   control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .branch_enable(branch_enable),
      .imm(imm), .bit11(bit11), .bit4(bit4), .addr_lsb(addr_lsb), .mem_resp(mem_resp),
      .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
      .load_mar(load_mar), .load_mdr(load_mdr), .load_cc(load_cc),
      .mask_enable(mask_enable), .truncate(truncate), .shift(shift),
      .pcmux_sel(pcmux_sel), .alumux_sel(alumux_sel), .regfilemux_sel(regfilemux_sel),
      .marmux_sel(marmux_sel), .storemux_sel(storemux_sel), .mdrmux_sel(mdrmux_sel),
      .adjmux_sel(adjmux_sel), .aluop(aluop), .aluop_imm(aluop_imm),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic out_t idle();
      out_t e = '0;
      e.aluop = alu_pass; e.aluop_imm = alu_pass; e.mbe = 2'b11;
      return e;
   endfunction

   function automatic out_t sample();
      out_t s;
      s.load_pc = load_pc; s.load_ir = load_ir; s.load_regfile = load_regfile;
      s.load_mar = load_mar; s.load_mdr = load_mdr; s.load_cc = load_cc;
      s.mask_enable = mask_enable; s.truncate = truncate; s.shift = shift;
      s.pcmux = pcmux_sel; s.alumux = alumux_sel; s.regfilemux = regfilemux_sel;
      s.marmux = marmux_sel; s.storemux = storemux_sel; s.mdrmux = mdrmux_sel;
      s.adjmux = adjmux_sel; s.aluop = aluop; s.aluop_imm = aluop_imm;
      s.mem_read = mem_read; s.mem_write = mem_write; s.mbe = mem_byte_enable;
      return s;
   endfunction

   task automatic push(input out_t e, input in_t i);
      exp_q.push_back(e);
      in_q.push_back(i);
   endtask

   task automatic apply(input in_t i);
      opcode = lc3b_opcode'(i.op); imm = i.imm; bit11 = i.b11; bit4 = i.b4;
      addr_lsb = i.lsb; branch_enable = i.be; mem_resp = i.resp;
   endtask

   // Reference: expected cycle-by-cycle outputs for one instruction.
   // flat/mlat = extra cycles memory withholds mem_resp for fetch / data access.
   task automatic build(input logic [3:0] op, input logic im, input logic b11,
                        input logic b4, input logic lsb, input logic be,
                        input int flat, input int mlat);
      out_t e;
      in_t  in;
      logic is_byte, is_load;
      in = '{op: op, imm: im, b11: b11, b4: b4, lsb: lsb, be: be, resp: 1'b0};
      is_byte = (op == 4'b0010) || (op == 4'b0011);
      is_load = (op == 4'b0110) || (op == 4'b0010);
      e = idle(); e.marmux = 2'd1; e.load_mar = 1; e.load_pc = 1;
      in.resp = 1'($urandom); push(e, in);
      for (int k = 0; k <= flat; k++) begin
         e = idle(); e.mem_read = 1; e.mdrmux = 1; e.load_mdr = 1;
         in.resp = (k == flat); push(e, in);
      end
      e = idle(); e.load_ir = 1; in.resp = 1'($urandom); push(e, in);
      e = idle(); in.resp = 1'($urandom); push(e, in);
      in.resp = 1'($urandom);
      case (op)
         4'b0001, 4'b0101, 4'b1001: begin
            e = idle(); e.load_regfile = 1; e.load_cc = 1;
            if (op == 4'b1001)      e.aluop = alu_not;
            else if (im)            e.aluop_imm = (op == 4'b0001) ? alu_add : alu_and;
            else                    e.aluop     = (op == 4'b0001) ? alu_add : alu_and;
            push(e, in);
         end
         4'b1101: begin
            e = idle(); e.alumux = 2'd2; e.load_regfile = 1; e.load_cc = 1;
            e.aluop = !b4 ? alu_sll : (im ? alu_sra : alu_srl);
            push(e, in);
         end
         4'b0000: begin
            push(idle(), in);
            if (be) begin
               e = idle(); e.pcmux = 2'd1; e.load_pc = 1;
               in.resp = 1'($urandom); push(e, in);
            end
         end
         4'b1100: begin
            e = idle(); e.pcmux = 2'd2; e.load_pc = 1; push(e, in);
         end
         4'b0100: begin
            e = idle(); e.regfilemux = 2'd3; e.load_regfile = 1; e.load_pc = 1;
            e.pcmux = b11 ? 2'd3 : 2'd2; push(e, in);
         end
         4'b1110: begin
            e = idle(); e.regfilemux = 2'd2; e.load_regfile = 1; e.load_cc = 1;
            push(e, in);
         end
         4'b0110, 4'b0010, 4'b0111, 4'b0011: begin
            e = idle(); e.alumux = 2'd1; e.aluop = alu_add; e.load_mar = 1;
            e.adjmux = is_byte; e.truncate = !is_byte; push(e, in);
            if (is_load) begin
               for (int k = 0; k <= mlat; k++) begin
                  e = idle(); e.mem_read = 1; e.mdrmux = 1; e.load_mdr = 1;
                  in.resp = (k == mlat); push(e, in);
               end
               e = idle(); e.regfilemux = 2'd1; e.load_regfile = 1; e.load_cc = 1;
               e.mask_enable = (op == 4'b0010); in.resp = 1'($urandom); push(e, in);
            end else begin
               e = idle(); e.storemux = 1; e.load_mdr = 1; e.shift = is_byte;
               in.resp = 1'($urandom); push(e, in);
               for (int k = 0; k <= mlat; k++) begin
                  e = idle(); e.mem_write = 1;
                  e.mbe = !is_byte ? 2'b11 : (lsb ? 2'b10 : 2'b01);
                  in.resp = (k == mlat); push(e, in);
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic test_reset();
      out_t exp_f1, got;
      reset = 1'b1; mem_resp = 1'b1;
      apply('{op: 4'b0110, imm: 1, b11: 1, b4: 1, lsb: 1, be: 1, resp: 1});
      @(posedge clk); #1;
      exp_f1 = idle(); exp_f1.marmux = 2'd1; exp_f1.load_mar = 1; exp_f1.load_pc = 1;
      for (int c = 0; c < 3; c++) begin
         #1; got = sample(); n_cmp++;
         if (got !== exp_f1) begin
            n_bad++; $display("FAIL reset_fetch1 cyc%0d: got %h expected %h", c, got, exp_f1);
         end
         @(posedge clk); #1;
      end
      reset = 1'b0;
   endtask

   task automatic test_add();
      out_t got;
      exp_q.delete(); in_q.delete();
      build(4'b0001, 1'b0, 0, 0, 0, 0, 0, 0);
      if (exp_q.size() != 5) begin
         n_bad++; $display("FAIL add_length: got %0d cycles expected 5", exp_q.size());
      end
      n_cmp++;
      for (int i = 0; i < exp_q.size(); i++) begin
         apply(in_q[i]); #1; got = sample(); n_cmp++;
         if (got !== exp_q[i]) begin
            n_bad++; $display("FAIL add cyc%0d: got %h expected %h", i, got, exp_q[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_ldr();
      out_t got;
      exp_q.delete(); in_q.delete();
      build(4'b0110, 1'b0, 0, 0, 0, 0, 1, 3);
      build(4'b0010, 1'b1, 0, 0, 1, 0, 0, 2);
      for (int i = 0; i < exp_q.size(); i++) begin
         apply(in_q[i]); #1; got = sample(); n_cmp++;
         if (got !== exp_q[i]) begin
            n_bad++; $display("FAIL load cyc%0d: got %h expected %h", i, got, exp_q[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_br();
      out_t got;
      exp_q.delete(); in_q.delete();
      build(4'b0000, 0, 0, 0, 0, 1'b0, 0, 0);
      build(4'b0000, 0, 0, 0, 0, 1'b1, 2, 0);
      build(4'b1100, 0, 0, 0, 0, 1'b1, 0, 0);
      build(4'b0100, 0, 1'b1, 0, 0, 0, 0, 0);
      build(4'b0100, 0, 1'b0, 0, 0, 0, 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         apply(in_q[i]); #1; got = sample(); n_cmp++;
         if (got !== exp_q[i]) begin
            n_bad++; $display("FAIL branch cyc%0d: got %h expected %h", i, got, exp_q[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stb();
      out_t got;
      exp_q.delete(); in_q.delete();
      build(4'b0011, 0, 0, 0, 1'b1, 0, 0, 1);
      build(4'b0011, 0, 0, 0, 1'b0, 0, 0, 0);
      build(4'b0111, 0, 0, 0, 1'b1, 0, 0, 2);
      for (int i = 0; i < exp_q.size(); i++) begin
         apply(in_q[i]); #1; got = sample(); n_cmp++;
         if (got !== exp_q[i]) begin
            n_bad++; $display("FAIL store cyc%0d: got %h expected %h", i, got, exp_q[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_store();
      out_t got;
      int   waits;
      exp_q.delete(); in_q.delete();
      build(4'b0111, 0, 0, 0, 0, 0, 0, 6);
      waits = 0;
      for (int i = 0; i < exp_q.size() && waits < 3; i++) begin
         apply(in_q[i]);
         if (exp_q[i].mem_write) begin
            waits++;
            if (waits == 3) reset = 1'b1;
         end
         #1; got = sample(); n_cmp++;
         if (got !== exp_q[i]) begin
            n_bad++; $display("FAIL st_wait cyc%0d: got %h expected %h", i, got, exp_q[i]);
         end
         @(posedge clk); #1;
      end
      // Held over one more edge so the next test starts in FETCH1
      mem_resp = 1'b1; #1; got = sample(); n_cmp++;
      if (got !== exp_q[0]) begin
         n_bad++; $display("FAIL reset_mid_store: got %h expected %h", got, exp_q[0]);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_trap();
      out_t got;
      exp_q.delete(); in_q.delete();
      build(4'b1111, 1, 1, 1, 1, 1, 0, 0);
      build(4'b1000, 0, 0, 0, 0, 0, 1, 0);
      build(4'b1010, 0, 0, 0, 0, 0, 0, 0);
      build(4'b1011, 1, 0, 0, 0, 0, 0, 0);
      build(4'b1110, 0, 0, 0, 0, 0, 0, 0);
      build(4'b1101, 0, 0, 1'b0, 0, 0, 0, 0);
      build(4'b1101, 0, 0, 1'b1, 0, 0, 0, 0);
      build(4'b1101, 1, 0, 1'b1, 0, 0, 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         apply(in_q[i]); #1; got = sample(); n_cmp++;
         if (got !== exp_q[i]) begin
            n_bad++; $display("FAIL noop_misc cyc%0d: got %h expected %h", i, got, exp_q[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      out_t got;
      exp_q.delete(); in_q.delete();
      for (int n = 0; n < 150; n++)
         build(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      for (int i = 0; i < exp_q.size(); i++) begin
         apply(in_q[i]); #1; got = sample(); n_cmp++;
         if (got !== exp_q[i]) begin
            n_bad++; $display("FAIL random cyc%0d op%0d: got %h expected %h",
                              i, in_q[i].op, got, exp_q[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      reset = 1'b1; mem_resp = 1'b0; imm = 0; bit11 = 0; bit4 = 0;
      addr_lsb = 0; branch_enable = 0; opcode = op_br;
      test_reset();
      test_add();
      test_ldr();
      test_br();
      test_stb();
      test_reset_mid_store();
      test_trap();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
